// File: rtl/acb_mem_arbiter_pkg.sv
// Shared ACB/AFB widths and types for the accelerator memory-port arbiter and its helpers.
package acb_mem_arbiter_pkg;

  localparam int unsigned ACB_REQ_W  = 110;
  localparam int unsigned ACB_RSP_W  = 65;
  localparam int unsigned AFB_ADDR_W = 36;
  localparam int unsigned AFB_DATA_W = 64;
  localparam int unsigned REQ_ID_W   = 2;

  typedef logic [REQ_ID_W-1:0]  req_id_t;
  typedef logic [ACB_REQ_W-1:0] acb_req_t;
  typedef logic [ACB_RSP_W-1:0] acb_rsp_t;

  function automatic int rr_next(input int g, input int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/acb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each outstanding memory request.
module acb_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/acb_mem_arbiter.sv
// Round-robin arbiter sharing the ACB memory port among NUM_REQ requesters; responses return
// in order and are routed back to their originator through a tag FIFO.
module acb_mem_arbiter
  import acb_mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_W           = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_write_req,
  output logic [NUM_REQ-1:0]             req_write_ack,
  input  logic [NUM_REQ*ACB_REQ_W-1:0]   req_write_data,
  input  logic [NUM_REQ-1:0]             rsp_read_req,
  output logic [NUM_REQ-1:0]             rsp_read_ack,
  output logic [ACB_RSP_W-1:0]           rsp_read_data,
  output logic [ACB_REQ_W-1:0]           ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic                           ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic                           ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
  input  logic [ACB_RSP_W-1:0]           ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  input  logic                           ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic                           ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
  output logic                           busy,
  output logic                           orphan_err
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic             out_valid_q, out_valid_d;
  acb_req_t         out_data_q, out_data_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic             orphan_q, orphan_d;

  logic             mem_drain, can_issue, grant_vld;
  logic [TAG_W-1:0] grant_id, head_id;
  acb_req_t         sel_data;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             rsp_vld;

  assign rsp_vld   = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
  assign mem_drain = out_valid_q && ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
  // The registered count is used so a slot freed by a pop only becomes usable next cycle.
  // Gating with reset keeps every ack low while reset is held.
  assign can_issue = reset && (!out_valid_q || mem_drain) && !fifo_full;

  always_comb begin
    grant_vld     = 1'b0;
    grant_id      = '0;
    sel_data      = '0;
    req_write_ack = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(rr_q) + k) % NUM_REQ && can_issue && !grant_vld && req_write_req[i]) begin
          grant_vld        = 1'b1;
          grant_id         = TAG_W'(i);
          sel_data         = req_write_data[i*ACB_REQ_W +: ACB_REQ_W];
          req_write_ack[i] = 1'b1;
        end
      end
    end
  end

  acb_tag_fifo #(
    .Depth (MAX_OUTSTANDING),
    .Width (TAG_W)
  ) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (grant_vld),
    .wdata_i (grant_id),
    .pop_i   (fifo_pop),
    .rdata_o (head_id),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    rsp_read_ack = '0;
    ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = 1'b0;
    if (!fifo_empty) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (head_id == TAG_W'(i)) begin
          rsp_read_ack[i] = rsp_vld;
          ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = rsp_read_req[i];
        end
      end
    end
  end

  assign fifo_pop      = rsp_vld && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack;
  assign rsp_read_data = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (grant_vld) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
    end else if (mem_drain) begin
      out_valid_d = 1'b0;
    end
    rr_d     = grant_vld ? TAG_W'(rr_next(int'(grant_id), NUM_REQ)) : rr_q;
    orphan_d = orphan_q || (rsp_vld && fifo_empty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_q        <= '0;
      orphan_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_q        <= rr_d;
      orphan_q    <= orphan_d;
    end
  end

  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack  = out_valid_q;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data = out_data_q;
  assign busy       = out_valid_q || (fifo_count != '0);
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_acb_mem_arbiter.sv
// Directed bench for acb_mem_arbiter: expected requests/responses are queued at issue time and
// checked by an independent monitor; a small memory model answers requests on demand.
module tb_acb_mem_arbiter;

  typedef struct {
    int          id;
    logic [64:0] data;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_v = '0, req_ack;
  logic [219:0] req_data = '0;
  logic [1:0]   rsp_rdy = '0, rsp_v;
  logic [64:0]  rsp_data;
  logic [109:0] mreq_data;
  logic         mreq_rdy = 1'b0, mreq_v;
  logic [64:0]  mrsp_data = '0;
  logic         mrsp_v = 1'b0, mrsp_ack;
  logic         busy, orphan;

  logic [109:0] exp_req_q [$];
  rsp_t         exp_rsp_q [$];
  logic [64:0]  mem_q [$];
  int           checks = 0, errors = 0;
  int           inj_cnt = 0, inj_seen = 0;
  logic [64:0]  inj_data = '0;
  bit           auto_rsp = 1'b0;

  acb_mem_arbiter #(
    .NUM_REQ         (2),
    .MAX_OUTSTANDING (4),
    .TAG_W           (2)
  ) dut (
    .clk                                          (clk),
    .reset                                        (rst_n),
    .req_write_req                                (req_v),
    .req_write_ack                                (req_ack),
    .req_write_data                               (req_data),
    .rsp_read_req                                 (rsp_rdy),
    .rsp_read_ack                                 (rsp_v),
    .rsp_read_data                                (rsp_data),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data   (mreq_data),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req    (mreq_rdy),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack    (mreq_v),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data (mrsp_data),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req  (mrsp_v),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack  (mrsp_ack),
    .busy                                         (busy),
    .orphan_err                                   (orphan)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [109:0] mk(input int id, input int n);
    logic [109:0] w;
    w = '0;
    w[109:108] = 2'(id);
    w[63:0] = 64'hC0DE_0000_0000_0000 | 64'(id << 8) | 64'(n);
    return w;
  endfunction

  task automatic exp_push(input int id, input logic [109:0] w, input bit with_rsp);
    rsp_t r;
    exp_req_q.push_back(w);
    if (with_rsp) begin
      r.id = id;
      r.data = {1'b0, w[63:0]};
      exp_rsp_q.push_back(r);
    end
  endtask

  task automatic inject(input int id, input logic [64:0] d, input bit expect_it);
    rsp_t r;
    inj_data = d;
    inj_cnt++;
    if (expect_it) begin
      r.id = id;
      r.data = d;
      exp_rsp_q.push_back(r);
    end
  endtask

  // Memory model: echoes the low 64 bits of each accepted request when auto_rsp is set.
  initial begin
    logic xr, xq;
    logic [109:0] qd;
    forever begin
      @(negedge clk);
      xr = mrsp_v && mrsp_ack;
      xq = mreq_v && mreq_rdy && auto_rsp;
      qd = mreq_data;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        mem_q.delete();
      end else begin
        if (xr && mem_q.size() > 0) void'(mem_q.pop_front());
        if (xq) mem_q.push_back({1'b0, qd[63:0]});
      end
      while (inj_seen != inj_cnt) begin
        mem_q.push_back(inj_data);
        inj_seen++;
      end
      mrsp_v = (mem_q.size() > 0);
      mrsp_data = (mem_q.size() > 0) ? mem_q[0] : '0;
    end
  end

  // Monitor: compares every transfer against the scoreboard queues.
  initial begin
    logic [109:0] er;
    rsp_t         ep;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mreq_v && mreq_rdy) begin
          if (exp_req_q.size() == 0) begin
            chk("mem_req_unexpected", 128'(mreq_data), 128'(0));
          end else begin
            er = exp_req_q.pop_front();
            chk("mem_req_data", 128'(mreq_data), 128'(er));
          end
        end
        if (rsp_v != 2'b00) chk("rsp_onehot", 128'($countones(rsp_v)), 128'(1));
        for (int i = 0; i < 2; i++) begin
          if (rsp_v[i] && rsp_rdy[i]) begin
            if (exp_rsp_q.size() == 0) begin
              chk("rsp_unexpected", 128'(i), 128'(99));
            end else begin
              ep = exp_rsp_q.pop_front();
              chk("rsp_id", 128'(i), 128'(ep.id));
              chk("rsp_data", 128'(rsp_data), 128'(ep.data));
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, n1, g;
    logic [109:0] w;
    n0 = 0;
    n1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ack", 128'(req_ack), 128'(0));
    chk("rst_mreq_v", 128'(mreq_v), 128'(0));
    chk("rst_mreq_data", 128'(mreq_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_orphan", 128'(orphan), 128'(0));
    chk("rst_rsp_v", 128'(rsp_v), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single read from requester 0
    w = 110'h1_0000_0040;
    mreq_rdy = 1'b1;
    rsp_rdy = 2'b11;
    req_data[109:0] = w;
    req_v = 2'b01;
    exp_req_q.push_back(w);
    @(negedge clk);
    chk("t1_grant", 128'(req_ack), 128'(2'b01));
    chk("t1_not_yet_valid", 128'(mreq_v), 128'(0));
    @(posedge clk); #1;
    req_v = 2'b00;
    @(negedge clk);
    chk("t1_req_valid", 128'(mreq_v), 128'(1));
    chk("t1_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    inject(0, 65'h0_DEAD_BEEF, 1'b1);
    @(negedge clk);
    chk("t1_rsp_route", 128'(rsp_v), 128'(2'b01));
    chk("t1_mem_rsp_ack", 128'(mrsp_ack), 128'(1));
    chk("t1_busy_outstanding", 128'(busy), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_idle", 128'(busy), 128'(0));

    // Fairness: rr pointer is 1 after the grant to requester 0
    auto_rsp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      g = (k % 2 == 0) ? 1 : 0;
      @(posedge clk); #1;
      req_data[109:0] = mk(0, n0);
      req_data[219:110] = mk(1, n1);
      req_v = 2'b11;
      exp_push(g, (g == 1) ? mk(1, n1) : mk(0, n0), 1'b1);
      @(negedge clk);
      chk("t2_grant", 128'(req_ack), 128'(2'b01 << g));
      if (g == 1) n1++; else n0++;
    end
    @(posedge clk); #1;
    req_v = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t2_idle", 128'(busy), 128'(0));
    chk("t2_rsp_drained", 128'(exp_rsp_q.size()), 128'(0));

    // Backpressure on the memory request pipe
    @(posedge clk); #1;
    mreq_rdy = 1'b0;
    req_data[109:0] = mk(0, n0);
    req_data[219:110] = mk(1, n1);
    req_v = 2'b11;
    w = mk(1, n1);
    exp_push(1, mk(1, n1), 1'b1);
    exp_push(0, mk(0, n0), 1'b1);
    @(negedge clk);
    chk("t3_grant", 128'(req_ack), 128'(2'b10));
    n1++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req_v = 2'b01;
      @(negedge clk);
      chk("t3_no_grant", 128'(req_ack), 128'(0));
      chk("t3_hold_valid", 128'(mreq_v), 128'(1));
      chk("t3_hold_data", 128'(mreq_data), 128'(w));
    end
    @(posedge clk); #1;
    mreq_rdy = 1'b1;
    @(negedge clk);
    chk("t3_drain_grant", 128'(req_ack), 128'(2'b01));
    n0++;
    @(posedge clk); #1;
    req_v = 2'b00;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t3_idle", 128'(busy), 128'(0));

    // Outstanding limit
    auto_rsp = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_data[109:0] = mk(0, n0);
      req_v = 2'b01;
      exp_req_q.push_back(mk(0, n0));
      @(negedge clk);
      chk("t4_grant", 128'(req_ack), 128'(2'b01));
      n0++;
    end
    @(posedge clk); #1;
    req_data[109:0] = mk(0, n0);
    exp_req_q.push_back(mk(0, n0));
    @(negedge clk);
    chk("t4_limit", 128'(req_ack), 128'(0));
    chk("t4_busy", 128'(busy), 128'(1));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_limit_hold", 128'(req_ack), 128'(0));
    @(posedge clk); #1;
    inject(0, 65'h1_0000_0000_0000_00A0, 1'b1);
    @(negedge clk);
    chk("t4_pop_ack", 128'(mrsp_ack), 128'(1));
    chk("t4_same_cycle", 128'(req_ack), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_next_cycle", 128'(req_ack), 128'(2'b01));
    n0++;
    @(posedge clk); #1;
    req_v = 2'b00;

    // Response stall: requester 0 not ready, FIFO stays full
    rsp_rdy = 2'b10;
    req_data[219:110] = mk(1, n1);
    req_v = 2'b10;
    inject(0, 65'h0_0000_0000_0000_00B1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_ack", 128'(mrsp_ack), 128'(0));
      chk("t5_rsp_valid", 128'(rsp_v), 128'(2'b01));
      chk("t5_fifo_full", 128'(req_ack), 128'(0));
      @(posedge clk); #1;
    end
    req_v = 2'b00;
    rsp_rdy = 2'b11;
    @(negedge clk);
    chk("t5_release", 128'(mrsp_ack), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      inject(0, 65'(64'h0000_0000_0000_00C0 + 64'(i)), 1'b1);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_idle", 128'(busy), 128'(0));
    chk("t5_rsp_drained", 128'(exp_rsp_q.size()), 128'(0));

    // Orphan response, then asynchronous reset mid-burst
    @(posedge clk); #1;
    inject(0, 65'h1_5555, 1'b0);
    @(negedge clk);
    chk("t6_orphan_ack", 128'(mrsp_ack), 128'(0));
    chk("t6_orphan_rsp_v", 128'(rsp_v), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_orphan_err", 128'(orphan), 128'(1));
    chk("t6_orphan_busy", 128'(busy), 128'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_orphan_cleared", 128'(orphan), 128'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_data[109:0] = mk(0, n0);
      req_v = 2'b01;
      exp_req_q.push_back(mk(0, n0));
      @(negedge clk);
      chk("t6_burst_grant", 128'(req_ack), 128'(2'b01));
      n0++;
      @(posedge clk); #1;
    end
    req_data[109:0] = mk(0, n0);
    req_data[219:110] = mk(1, n1);
    req_v = 2'b11;
    #3;
    rst_n = 1'b0;
    #1;
    exp_req_q.delete();
    exp_rsp_q.delete();
    chk("t6_rst_req_ack", 128'(req_ack), 128'(0));
    chk("t6_rst_mreq_v", 128'(mreq_v), 128'(0));
    chk("t6_rst_mreq_data", 128'(mreq_data), 128'(0));
    chk("t6_rst_busy", 128'(busy), 128'(0));
    chk("t6_rst_mrsp_ack", 128'(mrsp_ack), 128'(0));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    exp_req_q.push_back(mk(0, n0));
    @(negedge clk);
    chk("t6_rr_reset", 128'(req_ack), 128'(2'b01));
    @(posedge clk); #1;
    req_v = 2'b00;
    @(negedge clk);
    chk("t6_orphan_after", 128'(orphan), 128'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("end_req_q_empty", 128'(exp_req_q.size()), 128'(0));
    chk("end_rsp_q_empty", 128'(exp_rsp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
